// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with optional signed saturation.
// Block carries ripple through STAGES register stages under valid/ready flow control.
module csa_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             zero
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int MSB  = WIDTH - 1;

  // Element s holds the output of stage s; the last element is never loaded.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  bx_d  [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              cy_q  [STAGES];
  logic              cy_d  [STAGES];
  logic              sat_q [STAGES];
  logic              sat_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;

  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              of_q, of_d;
  logic              zero_q, zero_d;

  logic [STAGES-1:0] load;
  logic [STAGES:0]   vchain;
  logic              full;

  logic [WIDTH-1:0]  cur_a, cur_bx, cur_res, fin;
  logic              cur_cy, cur_sat, ovf;
  logic [BLOCK:0]    blk0, blk1;

  assign vchain    = {vld_q, in_valid};
  assign in_ready  = load[0];
  assign out_valid = vchain[STAGES];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign zero      = zero_q;

  // A stage may load if it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    full = 1'b1;
    load = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      full    = full & vld_q[s];
      load[s] = out_ready | ~full;
    end
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      vld_d[s] = load[s] ? vchain[s] : vld_q[s];
    end
  end

  always_comb begin
    a_d     = a_q;
    bx_d    = bx_q;
    res_d   = res_q;
    cy_d    = cy_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    of_d    = of_q;
    zero_d  = zero_q;
    cur_a   = '0;
    cur_bx  = '0;
    cur_res = '0;
    cur_cy  = 1'b0;
    cur_sat = 1'b0;
    fin     = '0;
    ovf     = 1'b0;
    blk0    = '0;
    blk1    = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        cur_a   = a;
        cur_bx  = sub ? ~b : b;
        cur_cy  = sub | cin;
        cur_res = '0;
        cur_sat = sat;
      end else begin
        cur_a   = a_q[(s > 0) ? s - 1 : 0];
        cur_bx  = bx_q[(s > 0) ? s - 1 : 0];
        cur_cy  = cy_q[(s > 0) ? s - 1 : 0];
        cur_res = res_q[(s > 0) ? s - 1 : 0];
        cur_sat = sat_q[(s > 0) ? s - 1 : 0];
      end
      // Blocks owned by this stage: both carry-in cases, then select on the running carry.
      for (int k = 0; k < NBLK; k++) begin
        if ((k * STAGES) / NBLK == s) begin
          blk0 = {1'b0, cur_a[k*BLOCK +: BLOCK]} + {1'b0, cur_bx[k*BLOCK +: BLOCK]};
          blk1 = {1'b0, cur_a[k*BLOCK +: BLOCK]} + {1'b0, cur_bx[k*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
          cur_res[k*BLOCK +: BLOCK] = cur_cy ? blk1[BLOCK-1:0] : blk0[BLOCK-1:0];
          cur_cy = cur_cy ? blk1[BLOCK] : blk0[BLOCK];
        end
      end
      if (s < STAGES - 1) begin
        if (load[s] && vchain[s]) begin
          a_d[s]   = cur_a;
          bx_d[s]  = cur_bx;
          res_d[s] = cur_res;
          cy_d[s]  = cur_cy;
          sat_d[s] = cur_sat;
        end
      end else begin
        ovf = (cur_a[MSB] == cur_bx[MSB]) && (cur_res[MSB] != cur_a[MSB]);
        fin = cur_res;
        if (cur_sat && ovf) begin
          fin = cur_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
        if (load[s] && vchain[s]) begin
          sum_d  = fin;
          cout_d = cur_cy;
          of_d   = ovf;
          zero_d = (fin == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        bx_q[s]  <= '0;
        res_q[s] <= '0;
        cy_q[s]  <= 1'b0;
        sat_q[s] <= 1'b0;
      end
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      bx_q   <= bx_d;
      res_q  <= res_d;
      cy_q   <= cy_d;
      sat_q  <= sat_d;
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      of_q   <= of_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Scoreboard bench for csa_addsub_pipe: a 32/8/2 instance and a 16/4/4 instance
// driven with directed vectors; monitors pop expected beats as results are consumed.
module tb_csa_addsub_pipe;
  typedef struct {
    string       nm;
    logic [31:0] sum;
    logic [2:0]  flg;   // {cout, of, zero}
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid32 = 1'b0, in_ready32, cin32 = 1'b0, sub32 = 1'b0, sat32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        out_valid32, out_ready32 = 1'b1, cout32, of32, zero32;

  logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0, sat16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        out_valid16, out_ready16 = 1'b1, cout16, of16, zero16;

  csa_addsub_pipe dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32), .sat(sat32),
    .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
    .cout(cout32), .of(of32), .zero(zero32)
  );

  csa_addsub_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .sat(sat16),
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
    .cout(cout16), .of(of16), .zero(zero16)
  );

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   acc32 = 0, done32 = 0, acc16 = 0, done16 = 0;
  logic        stall32 = 1'b0;
  logic [31:0] hold_sum32 = '0;
  logic [2:0]  hold_flg32 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc32 = 0; done32 = 0; acc16 = 0; done16 = 0;
    end else begin
      if (in_valid32 && in_ready32)   acc32++;
      if (out_valid32 && out_ready32) done32++;
      if (in_valid16 && in_ready16)   acc16++;
      if (out_valid16 && out_ready16) done16++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall32 = 1'b0;
    end else begin
      if (stall32 && out_valid32) begin
        chk("hold32_sum", sum32, hold_sum32);
        chk("hold32_flags", 32'({cout32, of32, zero32}), 32'(hold_flg32));
      end
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL extra32: unexpected result %h with nothing outstanding", sum32);
        end else begin
          e32 = q32.pop_front();
          chk({"sum32 ", e32.nm}, sum32, e32.sum);
          chk({"flags32 ", e32.nm}, 32'({cout32, of32, zero32}), 32'(e32.flg));
          if (e32.lat) chk({"latency32 ", e32.nm}, 32'(cyc - e32.acc), 32'd2);
        end
      end
      stall32    = out_valid32 && !out_ready32;
      hold_sum32 = sum32;
      hold_flg32 = {cout32, of32, zero32};
      chk("in_ready32", 32'(in_ready32), 32'(out_ready32 || ((acc32 - done32) < 2)));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL extra16: unexpected result %h with nothing outstanding", sum16);
        end else begin
          e16 = q16.pop_front();
          chk({"sum16 ", e16.nm}, 32'(sum16), e16.sum);
          chk({"flags16 ", e16.nm}, 32'({cout16, of16, zero16}), 32'(e16.flg));
          if (e16.lat) chk({"latency16 ", e16.nm}, 32'(cyc - e16.acc), 32'd4);
        end
      end
      chk("in_ready16", 32'(in_ready16), 32'(out_ready16 || ((acc16 - done16) < 4)));
    end
  end

  task automatic send32(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic isub, input logic isat,
                        input logic [31:0] es, input logic ec, input logic eo, input bit lat);
    exp_t e;
    bit   ok;
    a32 = ia; b32 = ib; cin32 = ic; sub32 = isub; sat32 = isat; in_valid32 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready32) ok = 1'b1;
    end
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL accept32 %s: in_ready low for 100 cycles, required 1", nm);
    end else begin
      e.nm = nm; e.sum = es; e.flg = {ec, eo, (es == 32'd0)}; e.acc = cyc; e.lat = lat;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic send16(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic isub, input logic isat,
                        input logic [31:0] es, input logic ec, input logic eo, input bit lat);
    exp_t e;
    bit   ok;
    a16 = ia; b16 = ib; cin16 = ic; sub16 = isub; sat16 = isat; in_valid16 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready16) ok = 1'b1;
    end
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL accept16 %s: in_ready low for 100 cycles, required 1", nm);
    end else begin
      e.nm = nm; e.sum = es; e.flg = {ec, eo, (es == 32'd0)}; e.acc = cyc; e.lat = lat;
      q16.push_back(e);
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (q32.size() != 0 || q16.size() != 0); n++) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid32", 32'(out_valid32), 32'd0);
    chk("rst_sum32", sum32, 32'd0);
    chk("rst_flags32", 32'({cout32, of32, zero32}), 32'd0);
    chk("rst_in_ready32", 32'(in_ready32), 32'd1);
    chk("rst_out_valid16", 32'(out_valid16), 32'd0);
    chk("rst_in_ready16", 32'(in_ready16), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    fork
      begin
        send32("add_of",      32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0, 1'b0, 32'hfffffffe, 1'b0, 1'b1, 1'b1);
        send32("add_of_sat",  32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0, 1'b1, 32'h7fffffff, 1'b0, 1'b1, 1'b1);
        send32("neg_of",      32'h8fffffff, 32'h8fffffff, 1'b0, 1'b0, 1'b0, 32'h1ffffffe, 1'b1, 1'b1, 1'b1);
        send32("neg_of_sat",  32'h8fffffff, 32'h8fffffff, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b1);
        send32("sub_cin_ign", 32'h000007aa, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h000007a9, 1'b1, 1'b0, 1'b1);
        send32("sub_zero",    32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        send32("sub_borrow",  32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'hffffffff, 1'b0, 1'b0, 1'b1);
      end
      begin
        send16("w16_sat",   16'h7fff, 16'h7fff, 1'b0, 1'b0, 1'b1, 32'h00007fff, 1'b0, 1'b1, 1'b1);
        send16("w16_nosat", 16'h7fff, 16'h7fff, 1'b0, 1'b0, 1'b0, 32'h0000fffe, 1'b0, 1'b1, 1'b1);
        send16("w16_sub",   16'h07aa, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h000007a9, 1'b1, 1'b0, 1'b1);
      end
    join
    drain();
    @(posedge clk); #1;

    fork
      begin
        for (int r = 0; r < 2; r++) begin
          send32("s_ffff", 32'hffffffff, 32'hffffffff, 1'b0, 1'b0, 1'b0, 32'hfffffffe, 1'b1, 1'b0, 1'b0);
          send32("s_00af", 32'h000000af, 32'h000000af, 1'b1, 1'b0, 1'b0, 32'h0000015f, 1'b0, 1'b0, 1'b0);
          send32("s_0123", 32'h00000123, 32'hfffff123, 1'b0, 1'b0, 1'b0, 32'hfffff246, 1'b0, 1'b0, 1'b0);
          send32("s_f999", 32'hfffff999, 32'h00000111, 1'b0, 1'b0, 1'b0, 32'hfffffaaa, 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready32 = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready32 = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    out_ready32 = 1'b0;
    send32("rs_drop_a", 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0);
    send32("rs_drop_b", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    q32.delete();
    #1;
    chk("arst_out_valid32", 32'(out_valid32), 32'd0);
    chk("arst_sum32", sum32, 32'd0);
    chk("arst_flags32", 32'({cout32, of32, zero32}), 32'd0);
    chk("arst_in_ready32", 32'(in_ready32), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    send32("post_rst", 32'h00000000, 32'hffffffff, 1'b0, 1'b0, 1'b0, 32'hffffffff, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("left32", 32'(q32.size()), 32'd0);
    chk("left16", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/csa_addsub_pipe.md
Name: csa_addsub_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit carry-select adder.
- Signed/unsigned add or subtract on WIDTH-bit operands.
- Carry-select blocks of BLOCK bits; block carry chain split across STAGES register stages.
- Optional signed saturation; valid/ready handshake on both sides; sits between operand-fetch and result-writeback in the datapath.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, carry-select block width in bits.
- STAGES, 2, pipeline register stages (1 .. WIDTH/BLOCK); equals latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored).
- sat  input  1  1: clamp signed result on overflow.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of MSB (for sub: 1 = no borrow).
- of  output  1  signed overflow of the unsaturated result.
- zero  output  1  final (post-saturation) sum == 0.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, sum=0, cout=0, of=0, zero=0. in_ready=1 during and after reset. A beat in flight when rst asserts is discarded, never emitted.
- Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Structure:
  - NBLK = WIDTH/BLOCK blocks.
  - Each block precomputes sum/carry for carry-in 0 and 1 in the stage it enters.
  - Block k selects its result in stage floor(k*STAGES/NBLK); the selected block carry is registered forward.
  - Flags and saturation are computed in the last stage.
- Latency: exactly STAGES cycles from input acceptance to out_valid with no stall. Throughput 1 beat/cycle.
- Flow control:
  - Per-stage valid bits, bubble-collapsing.
  - Stage i loads when it is empty or stage i+1 loads / the output is consumed.
  - in_ready = stage-0 loadable.
  - out_valid/sum/flags hold stable while out_valid && !out_ready.
  - No beat is dropped or duplicated; order is preserved.
- Arithmetic:
  - Effective b' = sub ? ~b : b; carry-in c0 = sub ? 1 : cin.
  - {cout, raw} = a + b' + c0, computed at WIDTH+1 bits.
  - of = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]).
- Saturation (sat=1 && of=1): sum = a[MSB] ? 1 followed by WIDTH-1 zeros (most negative) : 0 followed by WIDTH-1 ones (most positive). cout and of still report raw values.
- Otherwise: sum = raw.
- Per-beat mode: sub and sat are captured with the operands and travel with their beat; mixed-mode back-to-back beats are legal.
- Simultaneous events: with the pipe full and out_ready=1, a new input is accepted in the same cycle the oldest beat leaves. out_ready low with in_valid high fills the empty stages, then in_ready=0.

Test Plan:
- WIDTH=32, sat=0, sub=0, a=7fffffff, b=7fffffff, cin=0 -> sum=fffffffe, cout=0, of=1, zero=0 after exactly STAGES cycles.
  - Same operands with sat=1 -> sum=7fffffff, of=1.
- sub=0, a=8fffffff, b=8fffffff -> sum=1ffffffe, cout=1, of=1.
  - Same operands with sat=1 -> sum=80000000.
- sub=1, a=000007aa, b=00000001 (cin=1, must be ignored) -> sum=000007a9, cout=1, of=0.
  - sub=1, a=00000005, b=00000005 -> sum=0, zero=1, cout=1.
  - sub=1, a=0, b=1 -> sum=ffffffff, cout=0.
- Stream 8 beats back-to-back: ffffffff+ffffffff, 000000af+000000af with cin=1, 00000123+fffff123, fffff999+00000111 (repeat the set).
  - Hold out_ready=0 for 5 cycles mid-stream.
  - Required results: fffffffe/c1, 0000015f/c0, fffff246/c0, fffffaaa/c0, all of=0, in order, none lost or duplicated.
  - in_ready drops only once all stages are full; outputs stay stable while stalled.
- Assert rst for 1 cycle, asynchronously mid-cycle, with STAGES beats in flight -> out_valid=0 and all outputs 0 immediately. Those beats never appear.
  - The next accepted beat 0+ffffffff appears STAGES cycles later with sum=ffffffff, cout=0, of=0.
- Re-run the first and third scenarios with WIDTH=16, BLOCK=4, STAGES=4:
  - 7fff+7fff sat=1 -> 7fff.
  - 07aa-0001 -> 07a9.
  - Latency is 4 cycles.
